ecc_mult_arbiter: RTL and testbench

Shares one 384-bit Montgomery field multiplier among several ECC requesters, such as the point-arithmetic sequencer (mod p) and the signing/scalar-blinding logic (mod q). For each granted requester it latches that requester's operands and drives the multiplier's modulus and mu constants. It issues one start pulse per grant, returns the result to the owning requester, and flags multiplier protocol violations. It sits between the requesters and the multiplier inside the ECC core.

---
 rtl/ecc_params_pkg.sv | 43 ++++
 rtl/ecc_rr_arbiter.sv | 62 ++++++
 rtl/ecc_mult_arbiter.sv | 125 ++++++++++++
 tb/tb_ecc_mult_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_params_pkg.sv
// Shared ECC constants (NIST P-384 field prime, group order, Montgomery mu values)
// and the enums used by the multiplier arbiter.
package ecc_params_pkg;

   localparam int REG_SIZE   = 384;
   localparam int MULT_RADIX = 48;

   localparam logic [REG_SIZE-1:0] PRIME =
      384'hfffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffeffffffff0000000000000000ffffffff;
   localparam logic [REG_SIZE-1:0] GROUP_ORDER =
      384'hffffffffffffffffffffffffffffffffffffffffffffffffc7634d81f4372ddf581a0db248b0a77aecec196accc52973;
   // mu = -n^-1 mod 2^MULT_RADIX for each modulus
   localparam logic [MULT_RADIX-1:0] PRIME_mu       = 48'h000100000001;
   localparam logic [MULT_RADIX-1:0] GROUP_ORDER_mu = 48'h6089e88fdc45;

   typedef enum logic {
      MOD_P = 1'b0,
      MOD_Q = 1'b1
   } ecc_mod_sel_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } ecc_mult_arb_state_e;

   function automatic logic [REG_SIZE-1:0] modulus_of(input ecc_mod_sel_e sel);
      case (sel)
         MOD_P:   return PRIME;
         MOD_Q:   return GROUP_ORDER;
         default: return PRIME;
      endcase
   endfunction

   function automatic logic [MULT_RADIX-1:0] mu_of(input ecc_mod_sel_e sel);
      case (sel)
         MOD_P:   return PRIME_mu;
         MOD_Q:   return GROUP_ORDER_mu;
         default: return PRIME_mu;
      endcase
   endfunction

endpackage

// File: rtl/ecc_rr_arbiter.sv
// Combinational winner select: round-robin from ptr, or strict lowest-index priority
// when ECC_MULT_ARB_FIXED_PRIO_EN is defined.
module ecc_rr_arbiter
   import ecc_params_pkg::*;
#(
   parameter  int NUM_REQ = 3,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx
);

`ifdef ECC_MULT_ARB_FIXED_PRIO_EN
   logic unused_ptr_s;
   assign unused_ptr_s = ^ptr;

   // Lowest requesting index wins
   always_comb begin
      logic             found_v;
      logic             hit_v;
      logic [IDX_W-1:0] cand_v;
      gnt     = '0;
      idx     = '0;
      found_v = 1'b0;
      hit_v   = 1'b0;
      cand_v  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_v      = IDX_W'(i);
         hit_v       = req[cand_v] & ~found_v;
         gnt[cand_v] = gnt[cand_v] | hit_v;
         idx         = hit_v ? cand_v : idx;
         found_v     = found_v | hit_v;
      end
   end
`else
   // First requester at or after ptr wins, wrapping NUM_REQ-1 -> 0
   always_comb begin
      logic             found_v;
      logic             hit_v;
      logic [IDX_W-1:0] cand_v;
      int               pos_v;
      gnt     = '0;
      idx     = '0;
      found_v = 1'b0;
      hit_v   = 1'b0;
      cand_v  = '0;
      pos_v   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pos_v       = int'(ptr) + i;
         pos_v       = (pos_v >= NUM_REQ) ? pos_v - NUM_REQ : pos_v;
         cand_v      = IDX_W'(pos_v);
         hit_v       = req[cand_v] & ~found_v;
         gnt[cand_v] = gnt[cand_v] | hit_v;
         idx         = hit_v ? cand_v : idx;
         found_v     = found_v | hit_v;
      end
   end
`endif

endmodule

// File: rtl/ecc_mult_arbiter.sv
// Shares one Montgomery field multiplier among NUM_REQ ECC requesters.
// Build option: ECC_MULT_ARB_FIXED_PRIO_EN selects strict priority instead of round-robin.
module ecc_mult_arbiter
   import ecc_params_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int REG_SIZE   = ecc_params_pkg::REG_SIZE,
   parameter int MULT_RADIX = ecc_params_pkg::MULT_RADIX
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REQ-1:0]                 req_i,
   input  logic [NUM_REQ-1:0]                 mod_sel_i,
   input  logic [NUM_REQ-1:0][REG_SIZE-1:0]   opa_i,
   input  logic [NUM_REQ-1:0][REG_SIZE-1:0]   opb_i,
   output logic [NUM_REQ-1:0]                 gnt_o,
   output logic [NUM_REQ-1:0]                 res_valid_o,
   output logic [REG_SIZE-1:0]                res_o,
   output logic                               busy_o,
   output logic                               err_o,
   output logic                               mult_start_o,
   output logic [REG_SIZE-1:0]                mult_opa_o,
   output logic [REG_SIZE-1:0]                mult_opb_o,
   output logic [REG_SIZE-1:0]                mult_n_o,
   output logic [MULT_RADIX-1:0]              mult_mu_o,
   input  logic                               mult_done_i,
   input  logic [REG_SIZE-1:0]                mult_res_i
);

   localparam int IDX_W = $clog2(NUM_REQ);

   ecc_mult_arb_state_e    state_r, state_nxt_s;
   logic [IDX_W-1:0]       ptr_r, owner_r, win_idx_s;
   logic [NUM_REQ-1:0]     win_gnt_s, gnt_r, res_valid_r;
   logic                   win_valid_s, err_r, start_r;
   logic [REG_SIZE-1:0]    res_r, opa_r, opb_r, n_r;
   logic [MULT_RADIX-1:0]  mu_r;
   ecc_mod_sel_e           win_sel_s;

   ecc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req (req_i),
      .ptr (ptr_r),
      .gnt (win_gnt_s),
      .idx (win_idx_s)
   );

   assign win_valid_s = |win_gnt_s;
   assign win_sel_s   = ecc_mod_sel_e'(mod_sel_i[win_idx_s]);

   // Next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (win_valid_s) state_nxt_s = BUSY;
            else             state_nxt_s = IDLE;
         end
         BUSY: begin
            if (mult_done_i) state_nxt_s = RESP;
            else             state_nxt_s = BUSY;
         end
         RESP:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, operand latches and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         ptr_r       <= '0;
         owner_r     <= '0;
         gnt_r       <= '0;
         res_valid_r <= '0;
         res_r       <= '0;
         err_r       <= 1'b0;
         start_r     <= 1'b0;
         opa_r       <= '0;
         opb_r       <= '0;
         n_r         <= '0;
         mu_r        <= '0;
      end else begin
         state_r     <= state_nxt_s;
         gnt_r       <= '0;
         start_r     <= 1'b0;
         res_valid_r <= '0;
         // a done pulse outside BUSY has no owner to deliver to
         if (mult_done_i && (state_r != BUSY)) err_r <= 1'b1;
         else                                  err_r <= err_r;
         case (state_r)
            IDLE: begin
               if (win_valid_s) begin
                  gnt_r   <= win_gnt_s;
                  start_r <= 1'b1;
                  owner_r <= win_idx_s;
                  opa_r   <= opa_i[win_idx_s];
                  opb_r   <= opb_i[win_idx_s];
                  n_r     <= modulus_of(win_sel_s);
                  mu_r    <= mu_of(win_sel_s);
                  ptr_r   <= (win_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_s + IDX_W'(1);
               end
            end
            BUSY: begin
               if (mult_done_i) begin
                  res_r       <= mult_res_i;
                  res_valid_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_r;
               end
            end
            default: ;
         endcase
      end
   end

   assign gnt_o        = gnt_r;
   assign res_valid_o  = res_valid_r;
   assign res_o        = res_r;
   assign busy_o       = (state_r != IDLE);
   assign err_o        = err_r;
   assign mult_start_o = start_r;
   assign mult_opa_o   = opa_r;
   assign mult_opb_o   = opb_r;
   assign mult_n_o     = n_r;
   assign mult_mu_o    = mu_r;

endmodule

// File: tb/tb_ecc_mult_arbiter.sv
// Directed bench for ecc_mult_arbiter with a latency-configurable stub multiplier (opa*opb).
module tb_ecc_mult_arbiter;

   localparam logic [383:0] P_C =
      384'hfffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffeffffffff0000000000000000ffffffff;
   localparam logic [383:0] Q_C =
      384'hffffffffffffffffffffffffffffffffffffffffffffffffc7634d81f4372ddf581a0db248b0a77aecec196accc52973;
   localparam logic [47:0] PMU_C = 48'h000100000001;
   localparam logic [47:0] QMU_C = 48'h6089e88fdc45;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [2:0]         req_v = 3'b000;
   logic [2:0]         sel_v = 3'b000;
   logic [2:0][383:0]  opa_v = '0;
   logic [2:0][383:0]  opb_v = '0;
   logic [2:0]         gnt_o, res_valid_o;
   logic [383:0]       res_o, mult_opa_o, mult_opb_o, mult_n_o;
   logic               busy_o, err_o, mult_start_o;
   logic [47:0]        mult_mu_o;
   logic               mult_done_s;
   logic [383:0]       mult_res_s;

   int                 stub_lat = 5;
   int                 stub_cnt = 0;
   logic               stub_act = 1'b0;
   logic               stub_done = 1'b0;
   logic [383:0]       stub_a = '0, stub_b = '0, stub_res = '0;
   logic               tb_done = 1'b0;
   logic [383:0]       tb_res = '0;

   int checks = 0;
   int failures = 0;

   assign mult_done_s = stub_done | tb_done;
   assign mult_res_s  = tb_done ? tb_res : stub_res;

   always #5 clk = ~clk;

   ecc_mult_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req_i        (req_v),
      .mod_sel_i    (sel_v),
      .opa_i        (opa_v),
      .opb_i        (opb_v),
      .gnt_o        (gnt_o),
      .res_valid_o  (res_valid_o),
      .res_o        (res_o),
      .busy_o       (busy_o),
      .err_o        (err_o),
      .mult_start_o (mult_start_o),
      .mult_opa_o   (mult_opa_o),
      .mult_opb_o   (mult_opb_o),
      .mult_n_o     (mult_n_o),
      .mult_mu_o    (mult_mu_o),
      .mult_done_i  (mult_done_s),
      .mult_res_i   (mult_res_s)
   );

   // Stub multiplier: one-cycle done pulse stub_lat cycles after the start edge; not reset by rst
   always @(posedge clk) begin
      if (mult_start_o) begin
         stub_act  <= 1'b1;
         stub_cnt  <= stub_lat - 1;
         stub_a    <= mult_opa_o;
         stub_b    <= mult_opb_o;
         stub_done <= 1'b0;
      end else if (stub_act && stub_cnt <= 1) begin
         stub_act  <= 1'b0;
         stub_done <= 1'b1;
         stub_res  <= stub_a * stub_b;
      end else begin
         stub_done <= 1'b0;
         if (stub_act) stub_cnt <= stub_cnt - 1;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      req_v = 3'b000;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits up to 40 cycles for a result pulse; returns cycles waited (0 if none).
   task automatic wait_res(output int cyc);
      cyc = 0;
      for (int c = 1; c <= 40 && cyc == 0; c++) begin
         @(negedge clk);
         if (res_valid_o != 3'b000) cyc = c;
      end
   endtask

   typedef struct {
      logic [2:0]   req;
      logic [2:0]   sel;
      logic [15:0]  a;
      logic [15:0]  b;
      int           lat;
      logic [2:0]   exp_gnt;
      logic [383:0] exp_n;
      logic [47:0]  exp_mu;
      logic [383:0] exp_res;
   } vec_t;

   vec_t tbl[5];
   int   rr_exp[5];
   bit   served[3];
   int   cyc;
   int   seen;

   initial begin
      tbl[0] = '{3'b010, 3'b010, 16'd2,     16'd3,     5, 3'b010, Q_C, QMU_C, 384'd6};
      tbl[1] = '{3'b001, 3'b000, 16'd7,     16'd11,    3, 3'b001, P_C, PMU_C, 384'd77};
      tbl[2] = '{3'b100, 3'b100, 16'hffff,  16'hffff,  4, 3'b100, Q_C, QMU_C, 384'hfffe0001};
      tbl[3] = '{3'b101, 3'b100, 16'd100,   16'd200,   2, 3'b001, P_C, PMU_C, 384'd20000};
`ifdef ECC_MULT_ARB_FIXED_PRIO_EN
      tbl[4] = '{3'b101, 3'b001, 16'd300,   16'd5,     6, 3'b001, Q_C, QMU_C, 384'd1500};
      rr_exp = '{0, 0, 1, 2, 2};
`else
      tbl[4] = '{3'b101, 3'b001, 16'd300,   16'd5,     6, 3'b100, P_C, PMU_C, 384'd1500};
      rr_exp = '{0, 1, 2, 0, 2};
`endif

      // reset state
      do_reset();
      chk("rst_gnt", gnt_o, 0);
      chk("rst_res_valid", res_valid_o, 0);
      chk("rst_res", res_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_start", mult_start_o, 0);
      chk("rst_n", mult_n_o, 0);
      chk("rst_mu", mult_mu_o, 0);

      // table-driven single transactions
      for (int i = 0; i < 5; i++) begin
         stub_lat = tbl[i].lat;
         req_v    = tbl[i].req;
         sel_v    = tbl[i].sel;
         for (int r = 0; r < 3; r++) begin
            opa_v[r] = tbl[i].exp_gnt[r] ? 384'(tbl[i].a) : 384'hdead;
            opb_v[r] = tbl[i].exp_gnt[r] ? 384'(tbl[i].b) : 384'hbeef;
         end
         @(negedge clk);
         chk($sformatf("v%0d_gnt", i), gnt_o, tbl[i].exp_gnt);
         chk($sformatf("v%0d_start", i), mult_start_o, 1);
         chk($sformatf("v%0d_busy", i), busy_o, 1);
         chk($sformatf("v%0d_n", i), mult_n_o, tbl[i].exp_n);
         chk($sformatf("v%0d_mu", i), mult_mu_o, tbl[i].exp_mu);
         chk($sformatf("v%0d_opa", i), mult_opa_o, 384'(tbl[i].a));
         req_v = 3'b000;
         wait_res(cyc);
         chk($sformatf("v%0d_res_cycle", i), cyc + 1, tbl[i].lat + 2);
         chk($sformatf("v%0d_res_valid", i), res_valid_o, tbl[i].exp_gnt);
         chk($sformatf("v%0d_res", i), res_o, tbl[i].exp_res);
         @(negedge clk);
         chk($sformatf("v%0d_idle", i), busy_o, 0);
         chk($sformatf("v%0d_opa_hold", i), mult_opa_o, 384'(tbl[i].a));
      end

      // simultaneous requests with re-requests by 0 and 2
      do_reset();
      stub_lat = 3;
      sel_v    = 3'b000;
      for (int r = 0; r < 3; r++) begin
         opa_v[r] = 384'd3;
         opb_v[r] = 384'd5;
         served[r] = 1'b0;
      end
      req_v = 3'b111;
      for (int k = 0; k < 5; k++) begin
         seen = 0;
         for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (gnt_o != 3'b000) seen = 1;
         end
         chk($sformatf("rr%0d_onehot", k), gnt_o & (gnt_o - 3'd1), 0);
         chk($sformatf("rr%0d_order", k), gnt_o, 3'b001 << rr_exp[k]);
         req_v[rr_exp[k]] = 1'b0;
         wait_res(cyc);
         chk($sformatf("rr%0d_res", k), res_o, 384'd15);
         if (rr_exp[k] != 1 && !served[rr_exp[k]]) req_v[rr_exp[k]] = 1'b1;
         served[rr_exp[k]] = 1'b1;
      end
      @(negedge clk);
      chk("rr_no_err", err_o, 0);

      // spurious done in IDLE
      @(negedge clk);
      tb_res  = 384'h1234;
      tb_done = 1'b1;
      @(negedge clk);
      tb_done = 1'b0;
      chk("spur_err", err_o, 1);
      chk("spur_res_valid", res_valid_o, 0);
      chk("spur_res_kept", res_o, 384'd15);
      repeat (3) @(negedge clk);
      chk("spur_err_sticky", err_o, 1);
      chk("spur_idle", busy_o, 0);

      // reset while BUSY, late done arrives in IDLE
      do_reset();
      chk("rb_err_clr", err_o, 0);
      stub_lat = 8;
      sel_v    = 3'b000;
      opa_v[0] = 384'd9;
      opb_v[0] = 384'd9;
      req_v    = 3'b001;
      @(negedge clk);
      chk("rb_gnt", gnt_o, 3'b001);
      req_v = 3'b000;
      repeat (2) @(negedge clk);
      chk("rb_busy_before", busy_o, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rb_busy", busy_o, 0);
      chk("rb_opa", mult_opa_o, 0);
      chk("rb_opb", mult_opb_o, 0);
      chk("rb_n", mult_n_o, 0);
      chk("rb_mu", mult_mu_o, 0);
      chk("rb_res", res_o, 0);
      chk("rb_err", err_o, 0);
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (res_valid_o != 3'b000) seen++;
      end
      chk("rb_no_res_valid", seen, 0);
      chk("rb_late_done_err", err_o, 1);

      // done and new request in the same BUSY cycle
      do_reset();
      stub_lat = 4;
      opa_v[0] = 384'd4;
      opb_v[0] = 384'd6;
      opa_v[1] = 384'd10;
      opb_v[1] = 384'd10;
      req_v    = 3'b001;
      @(negedge clk);
      chk("dn_gnt0", gnt_o, 3'b001);
      req_v = 3'b000;
      seen = 0;
      for (int c = 0; c < 20 && seen == 0; c++) begin
         @(negedge clk);
         if (mult_done_s) seen = 1;
      end
      req_v = 3'b010;
      @(negedge clk);
      chk("dn_res_valid", res_valid_o, 3'b001);
      chk("dn_res", res_o, 384'd24);
      chk("dn_no_gnt_n1", gnt_o, 0);
      @(negedge clk);
      chk("dn_no_gnt_n2", gnt_o, 0);
      chk("dn_idle_n2", busy_o, 0);
      @(negedge clk);
      chk("dn_gnt1_n3", gnt_o, 3'b010);
      chk("dn_start_n3", mult_start_o, 1);
      req_v = 3'b000;
      wait_res(cyc);
      chk("dn_res_valid1", res_valid_o, 3'b010);
      chk("dn_res1", res_o, 384'd100);
      chk("dn_err", err_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
